// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sharing arbiter.
// The optional grant lock is enabled with ALU_ARB_LOCK_EN.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_SEL_W  = 3;

    localparam logic [ALU_SEL_W-1:0] ALU_OP_FWD = 3'b000;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_ADD = 3'b001;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_AND = 3'b010;
    localparam logic [ALU_SEL_W-1:0] ALU_OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    function automatic logic op_illegal(input logic [ALU_SEL_W-1:0] sel);
        return sel[ALU_SEL_W-1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin pick with LAST pointer.
// Grant lock is compiled in only with ALU_ARB_LOCK_EN.
module rr_arbiter2
    import alu_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_lock0,
    input  logic i_lock1,
    output logic o_grant0,
    output logic o_grant1,
    output logic o_last
);

    logic r_last;
    logic w_g0;
    logic w_g1;

`ifdef ALU_ARB_LOCK_EN
    logic r_locked;

    always_comb begin
        w_g1 = i_valid1 & (~i_valid0 | ~r_last);
        w_g0 = i_valid0 & ~w_g1;
        // while locked only the holder of LAST may be granted
        if (r_locked) begin
            w_g0 = i_valid0 & ~r_last;
            w_g1 = i_valid1 & r_last;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = i_lock0 ^ i_lock1;

    always_comb begin
        w_g1 = i_valid1 & (~i_valid0 | ~r_last);
        w_g0 = i_valid0 & ~w_g1;
    end
`endif

    assign o_grant0 = i_enable & w_g0;
    assign o_grant1 = i_enable & w_g1;
    assign o_last   = r_last;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
`ifdef ALU_ARB_LOCK_EN
            r_locked <= 1'b0;
`endif
        end else if (o_grant0) begin
            r_last <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            r_locked <= i_lock0;
`endif
        end else if (o_grant1) begin
            r_last <= 1'b1;
`ifdef ALU_ARB_LOCK_EN
            r_locked <= i_lock1;
`endif
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin grant.
// Optional grant lock: define ALU_ARB_LOCK_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SEL_W   = ALU_SEL_W,
    parameter int ALU_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [SEL_W-1:0]  REQ0_SELECT,
    input  logic [DATA_W-1:0] REQ0_A,
    input  logic [DATA_W-1:0] REQ0_B,
    input  logic              REQ0_LOCK,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [SEL_W-1:0]  REQ1_SELECT,
    input  logic [DATA_W-1:0] REQ1_A,
    input  logic [DATA_W-1:0] REQ1_B,
    input  logic              REQ1_LOCK,
    output logic              RSP0_VALID,
    output logic              RSP1_VALID,
    output logic [DATA_W-1:0] RSP_RESULT,
    output logic              RSP_ZERO,
    output logic              RSP_ERR,
    output logic [DATA_W-1:0] ALU_DATA1,
    output logic [DATA_W-1:0] ALU_DATA2,
    output logic [SEL_W-1:0]  ALU_SELECT,
    input  logic [DATA_W-1:0] ALU_RESULT,
    input  logic              ALU_ZERO
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    arb_state_t        r_state;
    logic [3:0]        r_cnt;
    logic              r_rsp0;
    logic              r_rsp1;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_err;
    logic [DATA_W-1:0] r_d1;
    logic [DATA_W-1:0] r_d2;
    logic [SEL_W-1:0]  r_sel;

    logic              w_idle;
    logic              w_g0;
    logic              w_g1;
    logic              w_last;
    logic              w_xfer;
    logic [SEL_W-1:0]  w_sel;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    assign w_idle = (r_state == ST_IDLE);
    assign w_xfer = w_g0 | w_g1;
    assign w_sel  = w_g0 ? REQ0_SELECT : REQ1_SELECT;
    assign w_a    = w_g0 ? REQ0_A : REQ1_A;
    assign w_b    = w_g0 ? REQ0_B : REQ1_B;

    rr_arbiter2 u_rr (
        .i_clk    (CLK),
        .i_rst_n  (RESET),
        .i_enable (w_idle),
        .i_valid0 (REQ0_VALID),
        .i_valid1 (REQ1_VALID),
        .i_lock0  (REQ0_LOCK),
        .i_lock1  (REQ1_LOCK),
        .o_grant0 (w_g0),
        .o_grant1 (w_g1),
        .o_last   (w_last)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rsp0   <= 1'b0;
            r_rsp1   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
            r_d1     <= '0;
            r_d2     <= '0;
            r_sel    <= '0;
        end else begin
            r_rsp0 <= 1'b0;
            r_rsp1 <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_xfer && op_illegal(w_sel)) begin
                        // illegal op never reaches the ALU
                        r_state  <= ST_RESP;
                        r_result <= '0;
                        r_zero   <= 1'b0;
                        r_err    <= 1'b1;
                        r_rsp0   <= w_g0;
                        r_rsp1   <= w_g1;
                    end else if (w_xfer) begin
                        r_state <= ST_BUSY;
                        r_d1    <= w_a;
                        r_d2    <= w_b;
                        r_sel   <= w_sel;
                        r_cnt   <= CNT_INIT;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= ST_RESP;
                        r_result <= ALU_RESULT;
                        r_zero   <= ALU_ZERO;
                        r_err    <= 1'b0;
                        r_rsp0   <= ~w_last;
                        r_rsp1   <= w_last;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign REQ0_READY = w_g0;
    assign REQ1_READY = w_g1;
    assign RSP0_VALID = r_rsp0;
    assign RSP1_VALID = r_rsp1;
    assign RSP_RESULT = r_result;
    assign RSP_ZERO   = r_zero;
    assign RSP_ERR    = r_err;
    assign ALU_DATA1  = r_d1;
    assign ALU_DATA2  = r_d2;
    assign ALU_SELECT = r_sel;

endmodule
